// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: opcode/funct values, ALU
// operation selector and the mul/div unit's operation and state types.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_LINK, ALU_MFHI, ALU_MFLO
  } alu_op_e;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative mul/div unit: shift-add multiplier and restoring divider on
// operand magnitudes, one bit per cycle, with sign fix-up into HI/LO.
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = $clog2(MULDIV_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0] p_q, p_d;
  logic [31:0] b_q, b_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic        div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic        signed_op, div_op;
  logic [31:0] amag, bmag, res_hi, res_lo;
  logic [32:0] mul_sum, div_sh, div_sub;
  logic [63:0] prod;

  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    div_op    = (op == MD_DIV) || (op == MD_DIVU);
    amag      = (signed_op && a[31]) ? 32'd0 - a : a;
    bmag      = (signed_op && b[31]) ? 32'd0 - b : b;

    // p holds {partial product, multiplier} or {remainder, quotient}
    mul_sum = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
    div_sh  = {p_q[63:32], p_q[31]};
    div_sub = div_sh - {1'b0, b_q};

    prod = neg_q ? 64'd0 - p_q : p_q;
    if (!div_q) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (dz_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rneg_q ? 32'd0 - p_q[63:32] : p_q[63:32];
      res_lo = neg_q  ? 32'd0 - p_q[31:0]  : p_q[31:0];
    end

    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    b_d     = b_q;
    a_d     = a_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (state_q == MD_RUN) begin
      if (div_q) begin
        p_d = (div_sh >= {1'b0, b_q}) ? {div_sub[31:0], p_q[30:0], 1'b1}
                                      : {div_sh[31:0], p_q[30:0], 1'b0};
      end else begin
        p_d = {mul_sum, p_q[31:1]};
      end
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) state_d = MD_DONE;
    end else begin
      if (state_q == MD_DONE) begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = MD_IDLE;
      end
      if (start) begin
        state_d = MD_RUN;
        count_d = CW'(MULDIV_CYCLES);
        p_d     = {32'd0, amag};
        b_d     = bmag;
        a_d     = a;
        div_d   = div_op;
        neg_d   = signed_op && (a[31] ^ b[31]);
        rneg_d  = signed_op && a[31];
        dz_d    = div_op && (b == 32'd0);
      end
    end

    // a later mthi/mtlo overrides a result retiring on the same edge
    if (hi_we) hi_d = wdata;
    if (lo_we) lo_d = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      p_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      b_q     <= b_d;
      a_q     <= a_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = (state_q == MD_DONE) ? res_hi : hi_q;
  assign lo   = (state_q == MD_DONE) ? res_lo : lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch/jump resolution, mul/div hazard stall and
// the EX/MEM pipeline register.
module ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        register_write,
  input  logic        branch,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [25:0] target,
  input  logic [31:0] pc,
  input  logic [31:0] value_1,
  input  logic [31:0] value_2,
  input  logic [31:0] value_3,
  input  logic        stall,
  output logic [4:0]  rd_o,
  output logic        register_write_o,
  output logic [31:0] result_o,
  output logic [31:0] store_data_o,
  output logic [5:0]  opcode_o,
  output logic [31:0] pc_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o,
  output logic        stall_o,
  output logic        muldiv_busy_o
);

  alu_op_e     alu_op;
  md_op_e      md_op;
  logic        valid, md_start, md_class, mthi, mtlo, use_imm, var_shift;
  logic        is_br_cond, br_eq, is_jump, taken, accept, bubble;
  logic [31:0] opb, alu_res, pc_plus4, tgt_calc, md_hi, md_lo;
  logic [4:0]  sh_amt;

  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d, taken_q, taken_d;
  logic [31:0] result_q, result_d, store_q, store_d, pc_q, pc_d, target_q, target_d;
  logic [5:0]  opcode_q, opcode_d;

  always_comb begin
    alu_op = ALU_NONE; md_op = MD_MULT; valid = 1'b1; md_start = 1'b0;
    md_class = 1'b0; mthi = 1'b0; mtlo = 1'b0; use_imm = 1'b0; var_shift = 1'b0;
    is_br_cond = 1'b0; br_eq = 1'b0; is_jump = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_SLLV: begin alu_op = ALU_SLL; var_shift = 1'b1; end
          F_SRLV: begin alu_op = ALU_SRL; var_shift = 1'b1; end
          F_SRAV: begin alu_op = ALU_SRA; var_shift = 1'b1; end
          F_MFHI: begin alu_op = ALU_MFHI; md_class = 1'b1; end
          F_MFLO: begin alu_op = ALU_MFLO; md_class = 1'b1; end
          F_MTHI: begin mthi = 1'b1; md_class = 1'b1; end
          F_MTLO: begin mtlo = 1'b1; md_class = 1'b1; end
          F_MULT:  begin md_start = 1'b1; md_class = 1'b1; md_op = MD_MULT;  end
          F_MULTU: begin md_start = 1'b1; md_class = 1'b1; md_op = MD_MULTU; end
          F_DIV:   begin md_start = 1'b1; md_class = 1'b1; md_op = MD_DIV;   end
          F_DIVU:  begin md_start = 1'b1; md_class = 1'b1; md_op = MD_DIVU;  end
          default: valid = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW:
        begin alu_op = ALU_ADD; use_imm = 1'b1; end
      OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_AND;  use_imm = 1'b1; end
      OP_ORI:   begin alu_op = ALU_OR;   use_imm = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XOR;  use_imm = 1'b1; end
      OP_LUI:   alu_op = ALU_LUI;
      OP_BEQ:   begin is_br_cond = 1'b1; br_eq = 1'b1; end
      OP_BNE:   is_br_cond = 1'b1;
      OP_J:     is_jump = 1'b1;
      OP_JAL:   begin is_jump = 1'b1; alu_op = ALU_LINK; end
      default:  valid = 1'b0;
    endcase
  end

  always_comb begin
    opb      = use_imm ? value_3 : value_2;
    sh_amt   = var_shift ? value_1[4:0] : shamt;
    pc_plus4 = pc + 32'd4;
    case (alu_op)
      ALU_ADD:  alu_res = value_1 + opb;
      ALU_SUB:  alu_res = value_1 - opb;
      ALU_AND:  alu_res = value_1 & opb;
      ALU_OR:   alu_res = value_1 | opb;
      ALU_XOR:  alu_res = value_1 ^ opb;
      ALU_NOR:  alu_res = ~(value_1 | opb);
      ALU_SLT:  alu_res = {31'd0, $signed(value_1) < $signed(opb)};
      ALU_SLTU: alu_res = {31'd0, value_1 < opb};
      ALU_SLL:  alu_res = value_2 << sh_amt;
      ALU_SRL:  alu_res = value_2 >> sh_amt;
      ALU_SRA:  alu_res = $signed(value_2) >>> sh_amt;
      ALU_LUI:  alu_res = {value_3[15:0], 16'h0000};
      ALU_LINK: alu_res = pc + 32'd8;
      ALU_MFHI: alu_res = md_hi;
      ALU_MFLO: alu_res = md_lo;
      default:  alu_res = '0;
    endcase
    tgt_calc = is_jump ? {pc_plus4[31:28], target, 2'b00}
                       : pc_plus4 + {value_3[29:0], 2'b00};
    taken    = branch && (is_jump || (is_br_cond && ((value_1 == value_2) == br_eq)));
  end

  always_comb begin
    stall_o  = muldiv_busy_o && md_class;
    accept   = !stall && !stall_o;
    bubble   = !valid || md_start || stall_o;
    rd_d     = rd_q;
    rw_d     = rw_q;
    result_d = result_q;
    store_d  = store_q;
    opcode_d = opcode_q;
    pc_d     = pc_q;
    target_d = target_q;
    taken_d  = 1'b0;
    if (!stall) begin
      pc_d = pc;
      if (bubble) begin
        rd_d = '0; rw_d = 1'b0; result_d = '0; store_d = '0;
        opcode_d = '0; target_d = '0;
      end else begin
        rd_d = rd; rw_d = register_write; result_d = alu_res; store_d = value_2;
        opcode_d = opcode; target_d = tgt_calc; taken_d = taken;
      end
    end
  end

  ex_muldiv #(.MULDIV_CYCLES(MULDIV_CYCLES)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && md_start),
    .op    (md_op),
    .a     (value_1),
    .b     (value_2),
    .hi_we (accept && mthi),
    .lo_we (accept && mtlo),
    .wdata (value_1),
    .busy  (muldiv_busy_o),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0; rw_q <= 1'b0; result_q <= '0; store_q <= '0;
      opcode_q <= '0; pc_q <= RESET_PC; target_q <= '0; taken_q <= 1'b0;
    end else begin
      rd_q <= rd_d; rw_q <= rw_d; result_q <= result_d; store_q <= store_d;
      opcode_q <= opcode_d; pc_q <= pc_d; target_q <= target_d; taken_q <= taken_d;
    end
  end

  assign rd_o             = rd_q;
  assign register_write_o = rw_q;
  assign result_o         = result_q;
  assign store_data_o     = store_q;
  assign opcode_o         = opcode_q;
  assign pc_o             = pc_q;
  assign branch_taken_o   = taken_q;
  assign branch_target_o  = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table-driven single-cycle vectors plus
// hand-written mul/div, stall and reset sequences, all via a scoreboard queue.
module tb_ex_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct, opcode_o;
  logic [4:0]  rd, shamt, rd_o;
  logic        register_write, branch, stall;
  logic [25:0] target;
  logic [31:0] pc, value_1, value_2, value_3;
  logic        register_write_o, branch_taken_o, stall_o, muldiv_busy_o;
  logic [31:0] result_o, store_data_o, pc_o, branch_target_o;

  ex_stage #(.MULDIV_CYCLES(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .rd(rd),
    .register_write(register_write), .branch(branch), .shamt(shamt),
    .funct(funct), .target(target), .pc(pc), .value_1(value_1),
    .value_2(value_2), .value_3(value_3), .stall(stall), .rd_o(rd_o),
    .register_write_o(register_write_o), .result_o(result_o),
    .store_data_o(store_data_o), .opcode_o(opcode_o), .pc_o(pc_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
    .stall_o(stall_o), .muldiv_busy_o(muldiv_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op; logic [5:0] fn; logic [4:0] sh; logic [4:0] rd;
    logic rw; logic br; logic [31:0] v1, v2, v3, pc; logic [25:0] tg;
  } in_t;

  typedef struct {
    string nm; in_t i; logic [31:0] res; logic cr; logic rw; logic tk; logic [31:0] tgt;
  } vec_t;

  typedef struct {
    string nm; logic [31:0] res; logic cr; logic [4:0] rd; logic rw; logic tk; logic [31:0] tgt;
  } exp_t;

  int unsigned checks = 0, errors = 0;
  exp_t sb[$];
  vec_t vecs[22];

  function automatic in_t mk(input logic [5:0] op, fn, input logic [4:0] sh, rdv,
                             input logic rw, br, input logic [31:0] v1, v2, v3, pcv,
                             input logic [25:0] tg);
    in_t x;
    x.op = op; x.fn = fn; x.sh = sh; x.rd = rdv; x.rw = rw; x.br = br;
    x.v1 = v1; x.v2 = v2; x.v3 = v3; x.pc = pcv; x.tg = tg;
    return x;
  endfunction

  function automatic in_t rr(input logic [5:0] fn, input logic [4:0] rdv, input logic rw,
                             input logic [31:0] v1, v2);
    return mk(6'h00, fn, 5'd0, rdv, rw, 1'b0, v1, v2, 32'd0, 32'h0000_0200, 26'd0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    opcode = x.op; funct = x.fn; shamt = x.sh; rd = x.rd; register_write = x.rw;
    branch = x.br; value_1 = x.v1; value_2 = x.v2; value_3 = x.v3; pc = x.pc; target = x.tg;
  endtask

  task automatic push(input string nm, input logic [31:0] res, input logic cr,
                      input logic [4:0] rdv, input logic rw, input logic tk,
                      input logic [31:0] tgt);
    exp_t e;
    e.nm = nm; e.res = res; e.cr = cr; e.rd = rdv; e.rw = rw; e.tk = tk; e.tgt = tgt;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".rw"}, register_write_o, e.rw);
      chk({e.nm, ".taken"}, branch_taken_o, e.tk);
      if (e.rw) chk({e.nm, ".rd"}, rd_o, e.rd);
      if (e.cr) chk({e.nm, ".result"}, result_o, e.res);
      if (e.tk) chk({e.nm, ".target"}, branch_target_o, e.tgt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".busy"}, muldiv_busy_o, 1'b0);
    chk({nm, ".result"}, result_o, 32'd0);
    chk({nm, ".rw"}, register_write_o, 1'b0);
    chk({nm, ".rd"}, rd_o, 5'd0);
    chk({nm, ".opcode"}, opcode_o, 6'd0);
    chk({nm, ".store"}, store_data_o, 32'd0);
    chk({nm, ".taken"}, branch_taken_o, 1'b0);
    chk({nm, ".target"}, branch_target_o, 32'd0);
    chk({nm, ".pc"}, pc_o, RST_PC);
  endtask

  // issue a mul/div, wait for completion, then read LO and HI back
  task automatic md_run(input string nm, input logic [5:0] fn, input logic [31:0] a, b,
                        input logic [31:0] exp_lo, exp_hi);
    int n;
    drive(rr(fn, 5'd0, 1'b0, a, b));
    push({nm, ".issue"}, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    step(); pop_cmp();
    drive(rr(6'h00, 5'd0, 1'b0, 32'd0, 32'd0));
    n = 0;
    while (muldiv_busy_o && n < 200) begin step(); n++; end
    chk({nm, ".latency"}, n, 32);
    drive(rr(6'h12, 5'd9, 1'b1, 32'd0, 32'd0));
    push({nm, ".lo"}, exp_lo, 1'b1, 5'd9, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();
    drive(rr(6'h10, 5'd10, 1'b1, 32'd0, 32'd0));
    push({nm, ".hi"}, exp_hi, 1'b1, 5'd10, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();
  endtask

  initial begin
    int n;
    logic ok;

    vecs[0]  = '{"addi",    mk(6'h08, 6'h00, 5'd0, 5'd7, 1, 0, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h10, 26'd0), 32'd2, 1, 1, 0, 32'd0};
    vecs[1]  = '{"add_wrap", rr(6'h20, 5'd8, 1, 32'h7FFF_FFFF, 32'd1), 32'h8000_0000, 1, 1, 0, 32'd0};
    vecs[2]  = '{"sub",     rr(6'h22, 5'd8, 1, 32'd3, 32'd5), 32'hFFFF_FFFE, 1, 1, 0, 32'd0};
    vecs[3]  = '{"and",     rr(6'h24, 5'd8, 1, 32'hF0F0, 32'hFF00), 32'h0000_F000, 1, 1, 0, 32'd0};
    vecs[4]  = '{"nor",     rr(6'h27, 5'd8, 1, 32'd0, 32'hF), 32'hFFFF_FFF0, 1, 1, 0, 32'd0};
    vecs[5]  = '{"slt",     rr(6'h2A, 5'd8, 1, 32'hFFFF_FFFF, 32'd1), 32'd1, 1, 1, 0, 32'd0};
    vecs[6]  = '{"sltu",    rr(6'h2B, 5'd8, 1, 32'hFFFF_FFFF, 32'd1), 32'd0, 1, 1, 0, 32'd0};
    vecs[7]  = '{"sra",     mk(6'h00, 6'h03, 5'd4, 5'd3, 1, 0, 32'd0, 32'h8000_0000, 32'd0, 32'h20, 26'd0), 32'hF800_0000, 1, 1, 0, 32'd0};
    vecs[8]  = '{"srlv",    rr(6'h06, 5'd8, 1, 32'h24, 32'h8000_0000), 32'h0800_0000, 1, 1, 0, 32'd0};
    vecs[9]  = '{"sllv",    rr(6'h04, 5'd8, 1, 32'd31, 32'd1), 32'h8000_0000, 1, 1, 0, 32'd0};
    vecs[10] = '{"lui",     mk(6'h0F, 6'h00, 5'd0, 5'd2, 1, 0, 32'hFFFF, 32'd0, 32'h0000_1234, 32'h30, 26'd0), 32'h1234_0000, 1, 1, 0, 32'd0};
    vecs[11] = '{"sltiu",   mk(6'h0B, 6'h00, 5'd0, 5'd2, 1, 0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h34, 26'd0), 32'd1, 1, 1, 0, 32'd0};
    vecs[12] = '{"ori",     mk(6'h0D, 6'h00, 5'd0, 5'd2, 1, 0, 32'h00FF_0000, 32'd0, 32'hF0, 32'h38, 26'd0), 32'h00FF_00F0, 1, 1, 0, 32'd0};
    vecs[13] = '{"lw",      mk(6'h23, 6'h00, 5'd0, 5'd4, 1, 0, 32'h1000, 32'd0, 32'hFFFF_FFFC, 32'h3C, 26'd0), 32'h0000_0FFC, 1, 1, 0, 32'd0};
    vecs[14] = '{"sw",      mk(6'h2B, 6'h00, 5'd0, 5'd0, 0, 0, 32'h2000, 32'hAB, 32'd8, 32'h40, 26'd0), 32'h0000_2008, 1, 0, 0, 32'd0};
    vecs[15] = '{"beq_t",   mk(6'h04, 6'h00, 5'd0, 5'd0, 0, 1, 32'd4, 32'd4, 32'd56, 32'h40, 26'd0), 32'd0, 0, 0, 1, 32'h0000_0124};
    vecs[16] = '{"beq_nt",  mk(6'h04, 6'h00, 5'd0, 5'd0, 0, 1, 32'd4, 32'd45, 32'd56, 32'h40, 26'd0), 32'd0, 0, 0, 0, 32'd0};
    vecs[17] = '{"bne_t",   mk(6'h05, 6'h00, 5'd0, 5'd0, 0, 1, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h100, 26'd0), 32'd0, 0, 0, 1, 32'h0000_0100};
    vecs[18] = '{"j",       mk(6'h02, 6'h00, 5'd0, 5'd0, 0, 1, 32'd0, 32'd0, 32'd0, 32'h3000_0010, 26'h100), 32'd0, 0, 0, 1, 32'h3000_0400};
    vecs[19] = '{"jal",     mk(6'h03, 6'h00, 5'd0, 5'd31, 1, 1, 32'd0, 32'd0, 32'd0, 32'h2000, 26'h40), 32'h0000_2008, 1, 1, 1, 32'h0000_0100};
    vecs[20] = '{"bad_op",  mk(6'h3F, 6'h00, 5'd0, 5'd5, 1, 0, 32'd1, 32'd1, 32'd1, 32'h50, 26'd0), 32'd0, 0, 0, 0, 32'd0};
    vecs[21] = '{"bad_fn",  rr(6'h01, 5'd5, 1, 32'd1, 32'd1), 32'd0, 0, 0, 0, 32'd0};

    rst_n = 1'b0;
    stall = 1'b0;
    drive(rr(6'h00, 5'd0, 1'b0, 32'd0, 32'd0));
    step(); step();
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].i);
      push(vecs[k].nm, vecs[k].res, vecs[k].cr, vecs[k].i.rd, vecs[k].rw, vecs[k].tk, vecs[k].tgt);
      step();
      pop_cmp();
      if (vecs[k].rw) chk({vecs[k].nm, ".pc"}, pc_o, vecs[k].i.pc);
    end

    // mult followed immediately by mflo: hazard stall, then forwarded LO
    @(negedge clk);
    drive(rr(6'h18, 5'd0, 1'b0, 32'hFFFF_FFFD, 32'd7));
    push("mult.issue", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    step(); pop_cmp();
    chk("mult.busy", muldiv_busy_o, 1'b1);
    drive(rr(6'h12, 5'd9, 1'b1, 32'd0, 32'd0));
    push("mult.mflo", 32'hFFFF_FFEB, 1'b1, 5'd9, 1'b1, 1'b0, 32'd0);
    n = 0; ok = 1'b1;
    while (stall_o && n < 200) begin
      step(); n++;
      if (register_write_o !== 1'b0 || branch_taken_o !== 1'b0) ok = 1'b0;
    end
    chk("mult.stall_cycles", n, 32);
    chk("mult.bubbles", ok, 1'b1);
    step(); pop_cmp();
    drive(rr(6'h10, 5'd10, 1'b1, 32'd0, 32'd0));
    push("mult.mfhi", 32'hFFFF_FFFF, 1'b1, 5'd10, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();

    md_run("div0",  6'h1A, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100);
    md_run("divu",  6'h1B, 32'd100, 32'd7, 32'd14, 32'd2);
    md_run("divneg", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    // downstream stall during an add while a multu keeps iterating
    @(negedge clk);
    drive(rr(6'h19, 5'd0, 1'b0, 32'd3, 32'd5));
    push("st.multu", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    step(); pop_cmp();
    drive(rr(6'h20, 5'd4, 1'b1, 32'd10, 32'd20));
    push("st.add30", 32'd30, 1'b1, 5'd4, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();
    stall = 1'b1;
    drive(rr(6'h12, 5'd9, 1'b1, 32'd0, 32'd0));
    #1 chk("st.stall_o_both", stall_o, 1'b1);
    drive(rr(6'h20, 5'd6, 1'b1, 32'd1, 32'd2));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("st.held_result", result_o, 32'd30);
      chk("st.held_rd", rd_o, 5'd4);
      chk("st.held_rw", register_write_o, 1'b1);
    end
    stall = 1'b0;
    push("st.add3", 32'd3, 1'b1, 5'd6, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();
    drive(rr(6'h00, 5'd0, 1'b0, 32'd0, 32'd0));
    n = 5;
    while (muldiv_busy_o && n < 200) begin step(); n++; end
    chk("st.md_done_edge", n, 32);
    drive(rr(6'h12, 5'd9, 1'b1, 32'd0, 32'd0));
    push("st.mflo", 32'd15, 1'b1, 5'd9, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();

    // mthi, then reset in the middle of a divide
    drive(rr(6'h11, 5'd0, 1'b0, 32'h55, 32'd0));
    push("mthi", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    step(); pop_cmp();
    drive(rr(6'h10, 5'd10, 1'b1, 32'd0, 32'd0));
    push("mthi.mfhi", 32'h55, 1'b1, 5'd10, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();
    drive(rr(6'h1A, 5'd0, 1'b0, 32'd1000, 32'd3));
    push("rst.div", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    step(); pop_cmp();
    drive(rr(6'h20, 5'd4, 1'b1, 32'd1, 32'd1));
    repeat (22) step();
    chk("rst.busy_before", muldiv_busy_o, 1'b1);
    rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    drive(rr(6'h10, 5'd10, 1'b1, 32'd0, 32'd0));
    push("rst.mfhi", 32'd0, 1'b1, 5'd10, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();
    drive(rr(6'h12, 5'd9, 1'b1, 32'd0, 32'd0));
    push("rst.mflo", 32'd0, 1'b1, 5'd9, 1'b1, 1'b0, 32'd0);
    step(); pop_cmp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
